or_gate_arbiter: RTL

//  Round-robin arbiter sharing one DATA_W-bit OR datapath (built from or_gate cells) among NUM_REQ requesters.

---
 rtl/or_gate_arbiter_pkg.sv | 15 +
 rtl/or_gate.sv | 10 +
 rtl/or_gate_arbiter_rr_priority_pick.sv | 27 ++
 rtl/or_gate_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/or_gate_arbiter_pkg.sv
// Shared types and helpers for the round-robin OR-datapath arbiter.
package or_gate_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/or_gate.sv
// Single-bit OR cell used as the shared datapath element.
module or_gate (
  input  logic i0,
  input  logic i1,
  output logic y_c
);

  assign y_c = i0 | i1;

endmodule

// File: rtl/or_gate_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at index >= ptr, wrapping.
module or_gate_arbiter_rr_priority_pick
  import or_gate_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_c,
  output logic [ID_W-1:0]    win_id_c
);

  // Lowest set request overall is the wrap fallback; lowest at/above ptr overrides it.
  always_comb begin
    win_id_c = '0;
    win_c    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_id_c = ID_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) win_id_c = ID_W'(i);
    end
    if (|req) win_c[win_id_c] = 1'b1;
  end

endmodule

// File: rtl/or_gate_arbiter.sv
// Round-robin arbiter sharing one registered OR datapath among NUM_REQ requesters.
// Optional HOLD timeout with ERR pulse enabled by defining OR_ARB_TIMEOUT_EN.
module or_gate_arbiter
  import or_gate_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 1,
`ifdef OR_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 15,
`endif
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] a_in,
  input  logic [NUM_REQ*DATA_W-1:0] b_in,
  input  logic                      ack,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ID_W-1:0]           gnt_id,
  output logic                      valid,
  output logic [DATA_W-1:0]         result,
  output logic                      err
);

  arb_state_t          state;
  logic [ID_W-1:0]     ptr;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   or_y_c;
  logic [DATA_W-1:0]   sel_a_c;
  logic [DATA_W-1:0]   sel_b_c;
  logic [NUM_REQ-1:0]  win_c;
  logic [ID_W-1:0]     win_id_c;
  logic                to_hit_c;
  logic                release_c;

  or_gate_arbiter_rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .win_c    (win_c),
    .win_id_c (win_id_c)
  );

  assign sel_a_c = a_in[win_id_c*DATA_W +: DATA_W];
  assign sel_b_c = b_in[win_id_c*DATA_W +: DATA_W];

  for (genvar g = 0; g < DATA_W; g++) begin : g_or
    or_gate u_or (
      .i0  (op_a[g]),
      .i1  (op_b[g]),
      .y_c (or_y_c[g])
    );
  end

  // ACK wins over a simultaneous timeout; both release the grant the same way.
  assign release_c = (state == ST_HOLD) && (ack || to_hit_c);

`ifdef OR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = id_width(TIMEOUT);

  logic [CNT_W-1:0] hold_cnt;

  assign to_hit_c = (32'(hold_cnt) == (TIMEOUT - 1));

  // Counts HOLD cycles; zero on every HOLD entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= (state == ST_HOLD) && !ack && to_hit_c;
      if (state != ST_HOLD)  hold_cnt <= '0;
      else if (!to_hit_c)    hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign to_hit_c = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      valid  <= 1'b0;
      result <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt    <= win_c;
            gnt_id <= win_id_c;
            op_a   <= sel_a_c;
            op_b   <= sel_b_c;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result <= or_y_c;
          valid  <= 1'b1;
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (release_c) begin
            valid <= 1'b0;
            gnt   <= '0;
            ptr   <= (32'(gnt_id) == (NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
